// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction buffer between the fetch and decode stages.
// Show-ahead head entry, full/valid decoded from registered pointers only,
// kill flushes the queue, and reset_i empties it asynchronously.
module fetch_queue #(
    parameter int DEPTH    = 4,   // power of two, at least 2
    parameter int ADDR_LEN = 32,
    parameter int INSN_LEN = 32
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       enq_valid_i,
    input  logic [INSN_LEN-1:0]        enq_inst_i,
    input  logic [ADDR_LEN-1:0]        enq_pc_i,
    output logic                       full_o,
    input  logic                       kill_i,
    input  logic                       deq_ready_i,
    output logic                       deq_valid_o,
    output logic [INSN_LEN-1:0]        deq_inst_o,
    output logic [ADDR_LEN-1:0]        deq_pc_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [INSN_LEN-1:0] inst_mem_r [0:DEPTH-1];
    logic [ADDR_LEN-1:0] pc_mem_r   [0:DEPTH-1];

    logic                empty_s;
    logic                full_s;
    logic                enq_fire_s;
    logic                deq_fire_s;
    logic [IDX_W-1:0]    wr_idx_s;
    logic [IDX_W-1:0]    rd_idx_s;

    assign wr_idx_s = wr_ptr_r[IDX_W-1:0];
    assign rd_idx_s = rd_ptr_r[IDX_W-1:0];

    // Occupancy decode from the registered pointers only.
    always_comb begin
        empty_s = (wr_ptr_r == rd_ptr_r);
        full_s  = (wr_idx_s == rd_idx_s) && (wr_ptr_r[IDX_W] != rd_ptr_r[IDX_W]);
    end

    // Transfer qualification; kill suppresses both directions.
    always_comb begin
        enq_fire_s = enq_valid_i && !full_s && !kill_i;
        deq_fire_s = deq_ready_i && !empty_s && !kill_i;
    end

    // Pointer update: kill collapses both pointers to zero, otherwise advance on transfers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else if (kill_i) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else begin
            if (enq_fire_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (deq_fire_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
        end
    end

    // Entry storage; contents are never cleared because outputs are masked when empty.
    always_ff @(posedge clk_i) begin
        if (enq_fire_s) begin
            inst_mem_r[wr_idx_s] <= enq_inst_i;
            pc_mem_r[wr_idx_s]   <= enq_pc_i;
        end
    end

    // Show-ahead head entry, forced to zero while the queue is empty.
    always_comb begin
        deq_inst_o = {INSN_LEN{1'b0}};
        deq_pc_o   = {ADDR_LEN{1'b0}};
        if (!empty_s) begin
            deq_inst_o = inst_mem_r[rd_idx_s];
            deq_pc_o   = pc_mem_r[rd_idx_s];
        end else begin
            deq_inst_o = {INSN_LEN{1'b0}};
            deq_pc_o   = {ADDR_LEN{1'b0}};
        end
    end

    // Status outputs; pointer difference wraps naturally modulo 2*DEPTH.
    always_comb begin
        full_o      = full_s;
        deq_valid_o = !empty_s;
        count_o     = wr_ptr_r - rd_ptr_r;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4: number of queue entries; SHALL be a power of two and at least 2.
REQ-002 Parameter ADDR_LEN, default 32: width of the PC field.
REQ-003 Parameter INSN_LEN, default 32: width of the instruction field.
REQ-004 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset_i  input  1  asynchronous, active-high reset.
REQ-006 enq_valid_i  input  1  fetch stage presents a valid instruction this cycle.
REQ-007 enq_inst_i  input  INSN_LEN  fetched instruction word.
REQ-008 enq_pc_i  input  ADDR_LEN  PC of the fetched instruction.
REQ-009 full_o  output  1  queue full; drives stall_IF of the fetch stage.
REQ-010 kill_i  input  1  flush request from branch/exception recovery.
REQ-011 deq_ready_i  input  1  decode stage accepts the head entry this cycle (~stall_ID).
REQ-012 deq_valid_o  output  1  head entry valid.
REQ-013 deq_inst_o  output  INSN_LEN  head instruction.
REQ-014 deq_pc_o  output  ADDR_LEN  head PC.
REQ-015 count_o  output  log2(DEPTH)+1  number of occupied entries.

Function
REQ-016 Storage SHALL be a circular buffer of DEPTH {inst, pc} entries, with read and write pointers of log2(DEPTH)+1 bits; the MSB SHALL be the wrap bit.
REQ-017 Empty SHALL be true when the pointers are equal; full SHALL be true when the index bits are equal and the wrap bits differ.
REQ-018 full_o and deq_valid_o SHALL be decoded from registered pointers only, with no combinational path from any input.
REQ-019 Enqueue SHALL occur on a rising edge when enq_valid_i=1, full_o=0 and kill_i=0: the entry is written at the write pointer and the write pointer increments modulo 2*DEPTH.
REQ-020 When enq_valid_i=1 and full_o=1, the enqueue SHALL be dropped and state SHALL NOT change; the fetch stage is responsible for holding via stall_IF.
REQ-021 Dequeue SHALL occur on a rising edge when deq_valid_o=1, deq_ready_i=1 and kill_i=0: the read pointer increments modulo 2*DEPTH.
REQ-022 deq_ready_i while empty SHALL have no effect.
REQ-023 deq_inst_o and deq_pc_o SHALL show the head entry combinationally from storage (show-ahead); both SHALL be 0 when the queue is empty.
REQ-024 Latency: an entry enqueued at edge N SHALL first appear on deq_* after edge N; there is no empty-queue bypass.
REQ-025 Simultaneous enqueue and dequeue in a non-empty, non-full queue SHALL leave count_o unchanged and preserve FIFO order.
REQ-026 When full, a simultaneous dequeue SHALL be accepted and the enqueue dropped, so count becomes DEPTH-1.
REQ-027 kill_i=1 at an edge SHALL set both pointers to 0, leaving the queue empty after the edge; kill_i overrides any enqueue or dequeue in the same cycle.
REQ-028 Storage contents need not be cleared on kill_i or reset; outputs SHALL be masked by the empty condition.
REQ-029 count_o SHALL equal write pointer minus read pointer, modulo 2*DEPTH, and SHALL stay in the range 0..DEPTH.
REQ-030 Pointer wrap-around SHALL be seamless: order and full/empty detection SHALL be correct across an arbitrary number of wraps.

Reset
REQ-031 While reset_i=1, immediately and without a clock edge: both pointers SHALL be 0, full_o=0, deq_valid_o=0, deq_inst_o=0, deq_pc_o=0, count_o=0.
REQ-032 Reset asserted mid-operation SHALL discard all entries asynchronously.
REQ-033 The first enqueue after reset deassertion SHALL be accepted on the first rising edge with reset_i=0.

Verification
REQ-034 Scenario, fill then drain: with DEPTH=4, enqueue pc 0x80000000..0x8000000C with deq_ready_i=0 -> full_o=1 and count_o=4 after the 4th edge. Then set deq_ready_i=1 -> the four entries appear in order and deq_valid_o=0 after 4 more edges.
REQ-035 Scenario, overflow drop: queue full, enq_valid_i=1 with pc 0x80000010, deq_ready_i=0 -> count_o stays 4 and the head stays 0x80000000.
REQ-036 Scenario, full with simultaneous enqueue/dequeue: queue full, enq_valid_i=1, deq_ready_i=1 -> count_o=3, the head advances to 0x80000004, and 0x80000010 is never observed.
REQ-037 Scenario, wrap-around streaming: 20 consecutive cycles with enqueue and deq_ready_i=1 -> every PC emerges exactly once, in order, one cycle after it is enqueued, and count_o never exceeds 1.
REQ-038 Scenario, kill during traffic: count_o=3 plus kill_i=1 together with enq_valid_i=1 and deq_ready_i=1 -> after the edge count_o=0, deq_valid_o=0 and deq_pc_o=0; the next enqueue appears at the head.
REQ-039 Scenario, async reset: count_o=2, reset_i pulsed between clock edges -> count_o=0 and deq_valid_o=0 before the next rising edge.
